// File: rtl/booth_mul_seq_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding and the operand extension used at accept time.
package booth_mul_seq_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Extends the low 'width' bits of op to MAX_W+1 bits; callers size-cast to WIDTH+1.
  function automatic logic [MAX_W:0] ext(input logic [MAX_W-1:0] op,
                                         input int               width,
                                         input logic             signed_mode);
    logic [MAX_W:0] r;
    logic           sign_bit;
    sign_bit = signed_mode & op[5'(width - 1)];
    r        = '0;
    for (int i = 0; i < MAX_W; i++) begin
      r[6'(i)] = (i < width) ? op[5'(i)] : sign_bit;
    end
    r[MAX_W] = sign_bit;
    return r;
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand/result handshake bundle between the datapath and the Booth multiplier.
// The master presents operands and consumes the product; the slave is the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mul_seq_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,Q_1} using the sign of the updated A.
module booth_mul_seq_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_q,
  input  logic           i_q1,
  input  logic [WIDTH:0] i_m,
  output logic [WIDTH:0] o_a,
  output logic [WIDTH:0] o_q,
  output logic           o_q1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves w_sum unassigned (no latch).
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: ;
    endcase
  end

  assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q  = {w_sum[0], i_q[WIDTH:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 cycles per product, valid/ready on both sides.
// Operands are extended to WIDTH+1 bits so one datapath serves signed and unsigned modes.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_q;
  logic               r_q1;
  logic [WIDTH:0]     r_m;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_step_en;
  logic               w_last;
  logic [WIDTH:0]     w_a_nxt;
  logic [WIDTH:0]     w_q_nxt;
  logic               w_q1_nxt;

  booth_mul_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_nxt),
    .o_q  (w_q_nxt),
    .o_q1 (w_q1_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step_en   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step_en = 1'b1;
        if (r_count == CNT_W'(WIDTH)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset clears the datapath as well, so an aborted operation leaves no visible residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_m     <= (WIDTH+1)'(ext(MAX_W'(bus.multiplicand), WIDTH, bus.signed_mode));
        r_q     <= (WIDTH+1)'(ext(MAX_W'(bus.multiplier), WIDTH, bus.signed_mode));
        r_a     <= '0;
        r_q1    <= 1'b0;
        r_count <= '0;
      end
      if (w_step_en) begin
        r_a     <= w_a_nxt;
        r_q     <= w_q_nxt;
        r_q1    <= w_q1_nxt;
        r_count <= r_count + 1'b1;
      end
      // The true product always fits 2*WIDTH bits, so the top two bits of {A,Q} are dropped.
      if (w_last) r_product <= (2*WIDTH)'({w_a_nxt, w_q_nxt});
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN) || (r_state == DONE);
  assign bus.product   = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH=8: directed vector table,
// handshake/reset corner sequences and a short reference-checked random run.
module tb_booth_mul_seq;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;

  booth_mul_seq_if #(.WIDTH(W)) bus ();

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    bus.in_valid     = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.signed_mode  = s;
    tick();
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.signed_mode  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s,
                       output logic [2*W-1:0] p, output int lat);
    start_op(m, q, s);
    wait_done(lat);
    p = bus.product;
    finish_op();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           vecs[13];
    logic [2*W-1:0] p;
    logic [2*W-1:0] held;
    int             lat;

    vecs[0]  = '{"s 7x-3",       8'h07, 8'hFD, 1'b1, 16'hFFEB};
    vecs[1]  = '{"s -128x-128",  8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{"s -128x127",   8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[3]  = '{"u 255x255",    8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[4]  = '{"u 128x2",      8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[5]  = '{"s -128x2",     8'h80, 8'h02, 1'b1, 16'hFF00};
    vecs[6]  = '{"s 0x5",        8'h00, 8'h05, 1'b1, 16'h0000};
    vecs[7]  = '{"u 1x1",        8'h01, 8'h01, 1'b0, 16'h0001};
    vecs[8]  = '{"s -1x-1",      8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9]  = '{"s -1x1",       8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[10] = '{"s 127x127",    8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[11] = '{"u 255x1",      8'hFF, 8'h01, 1'b0, 16'h00FF};
    vecs[12] = '{"u 18x52",      8'h12, 8'h34, 1'b0, 16'h03A8};

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.signed_mode  = 1'b0;
    bus.out_ready    = 1'b0;
    repeat (2) tick();
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy",      64'(bus.busy),      64'd0);
    check("reset product",   64'(bus.product),   64'd0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].m, vecs[i].q, vecs[i].s, p, lat);
      check({vecs[i].name, " product"}, 64'(p),   64'(vecs[i].exp));
      check({vecs[i].name, " latency"}, 64'(lat), 64'(LAT));
    end

    // Flags during RUN; in_valid in RUN must not disturb the operation
    start_op(8'h07, 8'hFD, 1'b1);
    check("run busy",     64'(bus.busy),     64'd1);
    check("run in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1; bus.multiplicand = 8'h55; bus.multiplier = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("run ignore product", 64'(bus.product), 64'hFFEB);
    check("run ignore latency", 64'(lat + 1),     64'(LAT));
    finish_op();

    // Stall in DONE for 5 cycles with in_valid pulses
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(lat);
    held = bus.product;
    check("stall product", 64'(held), 64'h03A8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid     = i[0];
      bus.multiplicand = 8'hFF;
      bus.multiplier   = 8'hFF;
      tick();
      check("stall out_valid", 64'(bus.out_valid), 64'd1);
      check("stall in_ready",  64'(bus.in_ready),  64'd0);
      check("stall held",      64'(bus.product),   64'h03A8);
    end
    bus.in_valid = 1'b0;
    finish_op();
    check("post hs out_valid", 64'(bus.out_valid), 64'd0);
    check("post hs in_ready",  64'(bus.in_ready),  64'd1);
    check("post hs busy",      64'(bus.busy),      64'd0);
    check("post hs product",   64'(bus.product),   64'h03A8);

    // Reset on the 4th RUN cycle
    start_op(8'h7F, 8'h7F, 1'b1);
    repeat (3) tick();
    check("pre-rst busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    check("mid rst product",   64'(bus.product),   64'd0);
    check("mid rst in_ready",  64'(bus.in_ready),  64'd1);
    check("mid rst busy",      64'(bus.busy),      64'd0);
    do_op(8'h03, 8'h05, 1'b0, p, lat);
    check("after rst 3x5", 64'(p),   64'h000F);
    check("after rst lat", 64'(lat), 64'(LAT));

    // Back-to-back: accept on the cycle right after the output handshake
    start_op(8'hFE, 8'h03, 1'b1);
    wait_done(lat);
    check("b2b first", 64'(bus.product), 64'hFFFA);
    finish_op();
    check("b2b ready", 64'(bus.in_ready), 64'd1);
    do_op(8'hF0, 8'h0F, 1'b0, p, lat);
    check("b2b second",     64'(p),   64'h0E10);
    check("b2b second lat", 64'(lat), 64'(LAT));

    // Random operations against an independent extended-operand reference
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0]   m, q;
      logic           s;
      logic [2*W-1:0] em, eq, ref_p;
      m     = W'($urandom);
      q     = W'($urandom);
      s     = 1'($urandom);
      em    = s ? {{W{m[W-1]}}, m} : {{W{1'b0}}, m};
      eq    = s ? {{W{q[W-1]}}, q} : {{W{1'b0}}, q};
      ref_p = em * eq;
      do_op(m, q, s, p, lat);
      check("random product", 64'(p), 64'(ref_p));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
